// File: rtl/dsram_pkg.sv
// Shared definitions for the SRAM-like data responder.
//   SZ_B/SZ_H/SZ_W : access-size encodings carried on the size bus
//   MAX_LAT        : largest response latency the 4-bit entry counter can hold
//   resp_entry_t   : one queued response {is_wr, data, cnt}
package dsram_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int MAX_LAT = 15;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] data;
        logic [3:0]  cnt;
    } resp_entry_t;

endpackage

// File: rtl/data_sram_like_responder_if.sv
// SRAM-like data bus between the CPU (master) and the memory responder (slave).
//   req/wr/size/wstrb/addr/wdata : request, driven by the CPU
//   addr_ok                      : request accepted when req & addr_ok
//   data_ok/rdata                : one-cycle in-order response
interface data_sram_like_responder_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/resp_queue.sv
// In-order response FIFO with a down-counter per entry.
//   clk, resetn : clock, async active-low reset
//   push        : enqueue push_entry (caller guarantees count < QDEPTH)
//   head_ready  : head entry valid and its counter has reached zero; the
//                 head pops on the same edge, since the CPU always sinks it
//   head_data   : head payload, forced to zero for store responses
//   count       : number of outstanding entries
module resp_queue
    import dsram_pkg::*;
#(
    parameter  int QDEPTH = 4,
    localparam int PTR_W  = $clog2(QDEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  resp_entry_t      push_entry,
    output logic             head_ready,
    output logic [31:0]      head_data,
    output logic [CNT_W-1:0] count
);

    resp_entry_t         ent [QDEPTH];
    logic [QDEPTH-1:0]   vld;
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic                pop;

    assign head_ready = vld[rptr] && (ent[rptr].cnt == 4'd0);
    assign head_data  = ent[rptr].is_wr ? 32'h0 : ent[rptr].data;
    assign pop        = head_ready;

    // The push slot is never valid (queue not full), so the push write and
    // the per-entry decrement never target the same entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (vld[i] && (ent[i].cnt != 4'd0)) begin
                    ent[i].cnt <= ent[i].cnt - 4'd1;
                end
            end
            if (push) begin
                ent[wptr] <= push_entry;
                vld[wptr] <= 1'b1;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_like_responder.sv
// Data-RAM stand-in for the CPU's SRAM-like data port. Requests are accepted
// through the addr_ok handshake and the array is accessed at the accept edge;
// responses return in order RESP_LAT cycles later through resp_queue.
//   clk      : clock, rising edge
//   resetn   : async active-low reset (array contents are kept)
//   stall_en : test control, holds addr_ok low
//   bus      : SRAM-like data bus, slave side
module data_sram_like_responder
    import dsram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int RESP_LAT   = 2,
    parameter int QDEPTH     = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic stall_en,
    data_sram_like_responder_if.slave bus
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    // Out-of-range latencies are clamped to what the entry counter can hold.
    localparam int LAT_C = (RESP_LAT < 1) ? 1 : ((RESP_LAT > MAX_LAT) ? MAX_LAT : RESP_LAT);
    localparam logic [3:0] LAT_M1 = 4'(LAT_C - 1);

    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] widx;
    logic                  accept;
    logic                  head_ready;
    logic [31:0]           head_data;
    logic [31:0]           rdata_q;
    logic [CNT_W-1:0]      count;
    resp_entry_t           push_entry;
    logic                  unused_bits;

    assign widx   = bus.addr[DEPTH_LOG2+1:2];

    // No bypass for a same-cycle pop: a full queue blocks acceptance.
    assign bus.addr_ok = resetn & ~stall_en & (count < CNT_W'(QDEPTH));
    assign accept      = bus.req & bus.addr_ok;

    // size is informational and the byte offset is the CPU's concern;
    // upper address bits simply alias.
    assign unused_bits = ^{bus.size, bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};

    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    mem[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Load data is the pre-edge word; only one request per cycle is accepted,
    // so a store from an earlier cycle is already in the array.
    always_comb begin
        push_entry       = '0;
        push_entry.is_wr = bus.wr;
        push_entry.data  = mem[widx];
        push_entry.cnt   = LAT_M1;
    end

    resp_queue #(
        .QDEPTH (QDEPTH)
    ) u_resp_queue (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_entry (push_entry),
        .head_ready (head_ready),
        .head_data  (head_data),
        .count      (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (head_ready) begin
            rdata_q <= head_data;
        end
    end

    assign bus.data_ok = head_ready;
    assign bus.rdata   = head_ready ? head_data : rdata_q;

endmodule

// File: tb/tb_data_sram_like_responder.sv
module tb_data_sram_like_responder;
    import dsram_pkg::*;

    localparam int LAT_A = 2;
    localparam int LAT_B = 8;
    localparam int QD    = 4;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic stall_dir2 = 1'b0, stall_dir8 = 1'b0;
    logic rnd_on = 1'b0, rnd2 = 1'b0, rnd8 = 1'b0;
    logic stall2, stall8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t        q2[$];
    exp_t        q8[$];
    logic [31:0] mm [2][4096];
    logic [31:0] last_rd [2];

    data_sram_like_responder_if b2();
    data_sram_like_responder_if b8();

    assign stall2 = rnd_on ? rnd2 : stall_dir2;
    assign stall8 = rnd_on ? rnd8 : stall_dir8;

    data_sram_like_responder #(.DEPTH_LOG2(12), .RESP_LAT(LAT_A), .QDEPTH(QD)) dut2 (
        .clk(clk), .resetn(resetn), .stall_en(stall2), .bus(b2));
    data_sram_like_responder #(.DEPTH_LOG2(12), .RESP_LAT(LAT_B), .QDEPTH(QD)) dut8 (
        .clk(clk), .resetn(resetn), .stall_en(stall8), .bus(b8));

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        rnd2 = ($urandom % 4) == 0;
        rnd8 = ($urandom % 4) == 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", name, $time, act, req);
        end
    endtask

    // Reference memory: word = (addr/4) mod 4096, strobed bytes replaced.
    function automatic logic [31:0] model(input int k, input logic w, input logic [3:0] sb,
                                          input logic [31:0] a, input logic [31:0] d);
        int idx;
        logic [31:0] r;
        idx = int'((a >> 2) & 32'hFFF);
        r = w ? 32'h0 : mm[k][idx];
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (sb[i]) mm[k][idx][8*i +: 8] = d[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Scoreboard push: any handshake seen on the bus is an accepted request.
    always @(posedge clk) begin
        cyc++;
        if (resetn) begin
            if (b2.req && b2.addr_ok)
                q2.push_back('{model(0, b2.wr, b2.wstrb, b2.addr, b2.wdata), cyc + LAT_A - 1});
            if (b8.req && b8.addr_ok)
                q8.push_back('{model(1, b8.wr, b8.wstrb, b8.addr, b8.wdata), cyc + LAT_B - 1});
        end
    end

    task automatic mon(input int k, input logic aok, input logic dok, input logic [31:0] rd,
                       input logic stl);
        int qs;
        exp_t f;
        qs = (k == 0) ? q2.size() : q8.size();
        f = '{32'h0, 0};
        if (qs > 0) f = (k == 0) ? q2[0] : q8[0];
        chk($sformatf("addr_ok[%0d]", k), 32'(aok), 32'(!stl && (qs < QD)));
        if (dok) begin
            checks++;
            if (qs == 0) begin
                failures++;
                $display("FAIL data_ok_unexpected[%0d] cyc=%0d actual=1 required=0", k, cyc);
            end else begin
                chk($sformatf("resp_cycle[%0d]", k), cyc, f.due);
                chk($sformatf("rdata[%0d]", k), rd, f.data);
                last_rd[k] = f.data;
                if (k == 0) void'(q2.pop_front()); else void'(q8.pop_front());
            end
        end else begin
            chk($sformatf("rdata_hold[%0d]", k), rd, last_rd[k]);
            if (qs > 0) begin
                checks++;
                if (f.due <= cyc) begin
                    failures++;
                    $display("FAIL data_ok_missing[%0d] cyc=%0d actual=0 required=1", k, cyc);
                    if (k == 0) void'(q2.pop_front()); else void'(q8.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            q2.delete();
            q8.delete();
            last_rd[0] = 32'h0;
            last_rd[1] = 32'h0;
        end else begin
            mon(0, b2.addr_ok, b2.data_ok, b2.rdata, stall2);
            mon(1, b8.addr_ok, b8.data_ok, b8.rdata, stall8);
        end
    end

    task automatic set_bus(input int k, input logic rq, input logic w, input logic [3:0] sb,
                           input logic [31:0] a, input logic [31:0] d);
        logic [1:0] sz;
        case ($countones(sb))
            1:       sz = SZ_B;
            2:       sz = SZ_H;
            default: sz = SZ_W;
        endcase
        if (k == 0) begin
            b2.req = rq; b2.wr = w; b2.size = sz; b2.wstrb = sb; b2.addr = a; b2.wdata = d;
        end else begin
            b8.req = rq; b8.wr = w; b8.size = sz; b8.wstrb = sb; b8.addr = a; b8.wdata = d;
        end
    endtask

    task automatic idle(input int k);
        set_bus(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input int k, input logic w, input logic [3:0] sb,
                         input logic [31:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        set_bus(k, 1'b1, w, sb, a, d);
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = (k == 0) ? b2.addr_ok : b8.addr_ok;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept_timeout[%0d] addr=0x%08h actual=no_accept required=accept", k, a);
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [3:0]  idx;
        int          k;

        idle(0);
        idle(1);
        #1;
        chk("reset_addr_ok", 32'(b2.addr_ok), 32'h0);
        chk("reset_data_ok", 32'(b2.data_ok), 32'h0);
        chk("reset_rdata", b2.rdata, 32'h0);
        chk("reset_addr_ok8", 32'(b8.addr_ok), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_cyc(1);

        // store then load of the same word
        issue(0, 1'b1, 4'hF, 32'h1C00_0000, 32'h1234_5678);
        issue(0, 1'b0, 4'h0, 32'h1C00_0000, 32'h0);
        idle(0);
        wait_cyc(4);

        // single-byte store into lane 2, then reload
        issue(0, 1'b1, 4'b0100, 32'h1C00_0002, 32'hAAAA_AAAA);
        issue(0, 1'b0, 4'h0, 32'h1C00_0000, 32'h0);
        idle(0);
        wait_cyc(4);

        for (int kk = 0; kk < 2; kk++) begin
            for (int w = 0; w < 16; w++) begin
                issue(kk, 1'b1, 4'hF, 32'h1C00_0000 + 32'(4 * w),
                      (w < 4) ? 32'(17 * (w + 1)) : $urandom);
            end
            idle(kk);
        end
        wait_cyc(12);

        // back-to-back loads, consecutive responses
        for (int w = 0; w < 4; w++) issue(0, 1'b0, 4'h0, 32'(4 * w), 32'h0);
        idle(0);
        wait_cyc(4);

        // long latency with req held: queue fills, then backpressure
        for (int w = 0; w < 5; w++) issue(1, 1'b0, 4'h0, 32'(4 * w), 32'h0);
        idle(1);
        wait_cyc(12);

        // stall_en holds off acceptance
        stall_dir2 = 1'b1;
        set_bus(0, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        wait_cyc(3);
        stall_dir2 = 1'b0;
        wait_cyc(1);
        idle(0);
        wait_cyc(4);

        // async reset with two loads in flight
        issue(1, 1'b0, 4'h0, 32'h18, 32'h0);
        issue(1, 1'b0, 4'h0, 32'h1C, 32'h0);
        idle(1);
        wait_cyc(2);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_data_ok8", 32'(b8.data_ok), 32'h0);
        chk("rst_addr_ok8", 32'(b8.addr_ok), 32'h0);
        chk("rst_rdata8", b8.rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_cyc(12);
        issue(1, 1'b0, 4'h0, 32'h0C, 32'h0);
        idle(1);
        wait_cyc(12);

        // randomized traffic with random stalls
        rnd_on = 1'b1;
        for (int n = 0; n < 400; n++) begin
            k = $urandom % 2;
            idle(1 - k);
            r = $urandom;
            idx = 4'($urandom % 16);
            issue(k, 1'($urandom % 2), 4'($urandom % 16),
                  {r[31:14], 8'h00, idx, r[1:0]}, $urandom);
            if ($urandom % 2 == 0) begin
                idle(k);
                wait_cyc($urandom % 3);
            end
        end
        rnd_on = 1'b0;
        idle(0);
        idle(1);
        wait_cyc(20);
        chk("drain_q2", q2.size(), 32'h0);
        chk("drain_q8", q8.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_sram_like_responder.md
Name: data_sram_like_responder

Overview:
- Memory-side responder for the CPU's SRAM-like data interface. Signals: req, wr, size, wstrb, addr, wdata, addr_ok, data_ok, rdata.
- Stands in for the data RAM behind the EXE/MEM stages during simulation and FPGA bring-up.
- Accepts requests through an address handshake and performs the memory access at acceptance.
- Returns in-order responses after a fixed latency, with a bounded number of outstanding requests.

Parameters:
- DEPTH_LOG2, 12, log2 of the number of 32-bit words in the internal array (4096 words = 16 KB).
- RESP_LAT, 2, cycles from accept edge to data_ok; legal range 1..15.
- QDEPTH, 4, maximum outstanding (accepted, not yet answered) requests; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- req  in  1  request valid from CPU.
- wr  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = half, 2 = word; informational only, wstrb governs writes.
- wstrb  in  4  byte write enables; ignored when wr = 0.
- addr  in  32  byte address.
- wdata  in  32  store data, already lane-replicated by the CPU.
- addr_ok  out  1  request accepted this cycle when req & addr_ok.
- data_ok  out  1  one-cycle response pulse; the CPU must always sink it.
- rdata  out  32  load data, valid when data_ok is high.
- stall_en  in  1  test control; forces addr_ok low.

Behaviour:
- Reset (resetn low, asynchronous): addr_ok = 0, data_ok = 0, rdata = 0, outstanding count = 0, queue pointers = 0.
  - Memory array contents are not cleared.
  - Reset mid-operation discards every outstanding response; no data_ok appears after reset release for those requests.
- addr_ok = resetn & ~stall_en & (count < QDEPTH). It is combinational and has no bypass for a same-cycle pop: a full queue holds addr_ok low for that cycle even if the head pops.
- Accept = req & addr_ok, sampled at the rising edge. On accept:
  - Word index = addr[DEPTH_LOG2+1:2]. Upper address bits alias; addr[1:0] is ignored (alignment faults are raised by the CPU).
  - Store: each byte i with wstrb[i] = 1 is written from wdata[8i+7:8i] at that edge.
  - Load: the current word is read at that edge. A store accepted in an earlier cycle is visible; there is no read-during-write hazard, because only one request is accepted per cycle.
  - An entry {is_wr, data, cnt = RESP_LAT-1} is pushed to the response queue.
- Each cycle, every valid entry with cnt > 0 decrements.
- data_ok = head valid & head cnt == 0.
  - rdata = head data for loads and 0 for stores (stores still receive data_ok).
  - The head pops on the same edge.
  - Registered outputs: a request accepted at edge T gives data_ok high in the cycle after edge T+RESP_LAT-1, i.e. the RESP_LAT-th cycle after acceptance.
- Ordering: responses are strictly in acceptance order, at most one per cycle.
  - Consecutive accepts produce consecutive data_ok pulses.
- Count update: push only gives +1; pop only gives -1; push and pop together leave count unchanged.
- Pointers wrap modulo QDEPTH.
- req held with addr_ok low has no side effects.
- stall_en may toggle at any time and affects only addr_ok.
- rdata holds its last value when data_ok is low.

Decomposition:
- Shared package dsram_pkg:
  - Size encodings SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2.
  - Response-entry typedef {is_wr, data[31:0], cnt[3:0]}.
  - Constant MAX_LAT = 15.
- One sub-module resp_queue: a QDEPTH-entry FIFO with per-entry down-counters.
  - Outputs: head_ready, head_data, count.
  - The top module holds the memory array, the accept logic and the byte-strobe merge.

Test Plan:
1. Store 0x1C000000 wstrb 4'b1111 wdata 0x12345678 accepted at edge T, then a load of the same address accepted at T+1 -> data_ok in the RESP_LAT-th cycle after each accept (2 cycles for default RESP_LAT = 2); the store returns rdata = 0 and the load returns 0x12345678.
2. After test 1, store addr 0x1C000002 size 0 wstrb 4'b0100 wdata 0xAAAAAAAA, then load 0x1C000000 -> rdata = 0x12AA5678.
3. Four loads on consecutive cycles to words 0..3 preloaded with 0x11, 0x22, 0x33, 0x44 -> four consecutive data_ok cycles, first two cycles after first accept, rdata in order 0x11, 0x22, 0x33, 0x44; addr_ok stays 1 (default RESP_LAT).
4. Instance with RESP_LAT = 8, QDEPTH = 4; req held high -> 4 accepts, then addr_ok = 0 until the cycle after the first data_ok pulse, then the 5th accept.
5. stall_en = 1 with req held for 3 cycles -> addr_ok = 0 and no data_ok; drop stall_en -> accept in that cycle, data_ok two cycles later.
6. Pull resetn low asynchronously with 2 requests outstanding (RESP_LAT = 8) -> data_ok and addr_ok drop immediately; after release no stale data_ok, addr_ok = 1, and a load of a previously stored word returns the stored value.
